// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares the single vga_adapter pixel-write port among N
// sprite drawers. Each drawer owns the port for a whole burst. Bursts are
// handed out in round-robin order. Pixels outside the screen are clipped.
// Optional: define VGA_ARB_WATCHDOG_EN to add an idle watchdog. That build
// adds the TIMEOUT parameter and the timeout output port.
module vga_write_arbiter #(
  parameter int N     = 4,
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240
`ifdef VGA_ARB_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     valid,
  input  logic [N-1:0]     last,
  input  logic [9*N-1:0]   x_in,
  input  logic [8*N-1:0]   y_in,
  input  logic [3*N-1:0]   colour_in,
  output logic [N-1:0]     gnt,
  output logic [8:0]       X,
  output logic [7:0]       Y,
  output logic [2:0]       colour,
  output logic             plot,
  output logic             busy,
  output logic [N-1:0]     burst_done
`ifdef VGA_ARB_WATCHDOG_EN
  ,
  output logic             timeout
`endif
);

  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  arbState_t       r_state, w_stateNext;
  logic [N-1:0]    r_gnt, w_gntNext;
  logic [N-1:0]    r_done, w_doneNext;
  logic [IdxW-1:0] r_gIdx, w_gIdxNext;
  logic [IdxW-1:0] r_rrPtr, w_rrPtrNext;
  logic            r_plot, w_plotNext;
  logic            w_capture;
  logic [8:0]      r_X;
  logic [7:0]      r_Y;
  logic [2:0]      r_colour;

  logic            w_anyReq;
  logic [IdxW-1:0] w_selIdx;
  logic [N-1:0]    w_selOneHot;

  logic            w_gReq, w_gValid, w_gLast;
  logic [8:0]      w_gX;
  logic [7:0]      w_gY;
  logic [2:0]      w_gColour;
  logic [N-1:0]    w_gOneHot;
  logic            w_inRange;
  logic [IdxW-1:0] w_ptrAfterG;

`ifdef VGA_ARB_WATCHDOG_EN
  localparam logic [9:0] IdleLimit = 10'(TIMEOUT - 1);
  logic [9:0] r_idle, w_idleNext;
  logic       r_timeout, w_timeoutNext;
`endif

  assign w_anyReq    = |req;
  assign w_ptrAfterG = (r_gIdx == IdxW'(N - 1)) ? '0 : r_gIdx + 1'b1;
  assign w_inRange   = ({1'b0, w_gX} < 10'(X_MAX)) && ({1'b0, w_gY} < 9'(Y_MAX));

  // Round-robin pick: the first requesting index, scanning upward from rr_ptr with wrap.
  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found       = 1'b0;
    cand        = '0;
    w_selIdx    = '0;
    w_selOneHot = '0;
    for (int i = 0; i < N; i++) begin
      cand = IdxW'((int'(r_rrPtr) + i) % N);
      if (!found && req[cand]) begin
        found    = 1'b1;
        w_selIdx = cand;
      end
    end
    for (int k = 0; k < N; k++) begin
      w_selOneHot[k] = (w_selIdx == IdxW'(k));
    end
  end

  // Route the current owner's request, pixel and burst-control signals.
  always_comb begin
    w_gReq    = 1'b0;
    w_gValid  = 1'b0;
    w_gLast   = 1'b0;
    w_gX      = '0;
    w_gY      = '0;
    w_gColour = '0;
    w_gOneHot = '0;
    for (int k = 0; k < N; k++) begin
      if (r_gIdx == IdxW'(k)) begin
        w_gReq       = req[k];
        w_gValid     = valid[k];
        w_gLast      = last[k];
        w_gX         = x_in[9*k +: 9];
        w_gY         = y_in[8*k +: 8];
        w_gColour    = colour_in[3*k +: 3];
        w_gOneHot[k] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> GRANT -> RELEASE burst cycle.
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    w_gIdxNext  = r_gIdx;
    w_rrPtrNext = r_rrPtr;
    w_plotNext  = 1'b0;
    w_doneNext  = '0;
    w_capture   = 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
    w_idleNext    = r_idle;
    w_timeoutNext = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
`ifdef VGA_ARB_WATCHDOG_EN
        w_idleNext = '0;
`endif
        if (w_anyReq) begin
          w_stateNext = GRANT;
          w_gntNext   = w_selOneHot;
          w_gIdxNext  = w_selIdx;
        end
      end
      GRANT: begin
        if (w_gValid) begin
          w_capture  = 1'b1;
          w_plotNext = w_inRange;
`ifdef VGA_ARB_WATCHDOG_EN
          w_idleNext = '0;
        end else begin
          w_idleNext = r_idle + 10'd1;
`endif
        end
        if (w_gValid && w_gLast) begin
          w_stateNext = RELEASE;
          w_gntNext   = '0;
          w_rrPtrNext = w_ptrAfterG;
          w_doneNext  = w_gOneHot;
        end else if (!w_gReq) begin
          w_stateNext = RELEASE;
          w_gntNext   = '0;
          w_rrPtrNext = w_ptrAfterG;
        end
`ifdef VGA_ARB_WATCHDOG_EN
        else if (!w_gValid && (r_idle == IdleLimit)) begin
          w_stateNext   = RELEASE;
          w_gntNext     = '0;
          w_rrPtrNext   = w_ptrAfterG;
          w_timeoutNext = 1'b1;
        end
`endif
      end
      RELEASE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_gntNext   = '0;
      end
    endcase
  end

  // Control registers; reset wins over everything, so any in-flight pixel is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gIdx  <= '0;
      r_rrPtr <= '0;
      r_plot  <= 1'b0;
      r_done  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      r_gIdx  <= w_gIdxNext;
      r_rrPtr <= w_rrPtrNext;
      r_plot  <= w_plotNext;
      r_done  <= w_doneNext;
    end
  end

  // Pixel registers follow every valid pixel, clipped or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_X      <= '0;
      r_Y      <= '0;
      r_colour <= '0;
    end else if (w_capture) begin
      r_X      <= w_gX;
      r_Y      <= w_gY;
      r_colour <= w_gColour;
    end
  end

`ifdef VGA_ARB_WATCHDOG_EN
  // Idle counter and the timeout pulse that marks a forced release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_idle    <= w_idleNext;
      r_timeout <= w_timeoutNext;
    end
  end

  assign timeout = r_timeout;
`endif

  assign gnt        = r_gnt;
  assign X          = r_X;
  assign Y          = r_Y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign busy       = (r_state != IDLE);
  assign burst_done = r_done;

endmodule
